// File: rtl/pc_next_unit_pkg.sv
// rtl/pc_next_unit_pkg.sv - shared fetch-unit types and constants
package pc_next_unit_pkg;

  // Fetch FSM: RUN fetches normally, REDIR squashes the wrong-path instruction
  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Every instruction occupies one 32-bit word
  localparam logic [31:0] INSN_BYTES = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - redirect target selection for jumps and branches
module pc_target_calc
  import pc_next_unit_pkg::*;
(
  input  logic [31:0] dec_pc,
  input  logic [31:0] br_offset,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  output logic [31:0] target
);

  logic [31:0] br_target;

  // Branch offset is in words and relative to the instruction after the branch
  assign br_target = dec_pc + INSN_BYTES + (br_offset << 2);

  // A jump wins over a branch seen in the same cycle
  assign target = jmp_valid ? jmp_target : br_target;

endmodule

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - next fetch address, redirect flush and taken counter
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [1:0]       bcres,
  input  logic [31:0]      br_offset,
  input  logic             jmp_valid,
  input  logic [31:0]      jmp_target,
  output logic [31:0]      pc,
  output logic [31:0]      dec_pc,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  pc_state_e   state_q;
  pc_state_e   state_d;
  logic        redirect;
  logic [31:0] target;
  logic        bcres_unused;

  // Only the condition-true bit of the evaluator result matters here
  assign bcres_unused = bcres[1];

  pc_target_calc u_target (
    .dec_pc     (dec_pc),
    .br_offset  (br_offset),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .target     (target)
  );

  // Redirect requests are only honoured while running and not stalled
  assign redirect = (state_q == RUN) && !stall &&
                    (jmp_valid || (br_valid && bcres[0]));

  // Squash lasts exactly as long as the REDIR state, so it is registered
  assign flush = (state_q == REDIR);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stall freezes, REDIR always lasts one advancing cycle
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        RUN:     state_d = redirect ? REDIR : RUN;
        REDIR:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Fetch and decode addresses follow the pipeline unless stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      dec_pc <= RESET_PC;
    end else if (!stall) begin
      pc     <= redirect ? target : pc + INSN_BYTES;
      dec_pc <= pc;
    end
  end

  // Saturating count of redirects taken
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (redirect && (taken_cnt != {CNT_W{1'b1}})) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - randomized and directed bench for pc_next_unit
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [1:0]  bcres;
  logic [31:0] br_offset;
  logic        jmp_valid;
  logic [31:0] jmp_target;

  logic [31:0] pc, dec_pc, pc2, dec_pc2;
  logic        flush, flush2;
  logic [15:0] taken_cnt;
  logic [1:0]  taken_cnt2;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_dec;
  bit          m_redir;
  int          m_cnt;
  bit          m_valid = 0;

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .bcres(bcres),
    .br_offset(br_offset), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .pc(pc), .dec_pc(dec_pc), .flush(flush), .taken_cnt(taken_cnt)
  );

  pc_next_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .bcres(bcres),
    .br_offset(br_offset), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .pc(pc2), .dec_pc(dec_pc2), .flush(flush2), .taken_cnt(taken_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pipeline of addresses plus a one-cycle squash flag
  always @(posedge clk) begin
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_dec = 32'h0; m_redir = 0; m_cnt = 0; m_valid = 1;
    end else if (!stall) begin
      if (!m_redir && (jmp_valid || (br_valid && bcres[0]))) begin
        tgt = jmp_valid ? jmp_target : m_dec + 32'd4 + br_offset * 32'd4;
        m_dec = m_pc; m_pc = tgt; m_redir = 1; m_cnt = m_cnt + 1;
      end else begin
        m_dec = m_pc; m_pc = m_pc + 32'd4; m_redir = 0;
      end
    end
  end

  // Compare both instances to the model away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc", pc, m_pc);
      check("dec_pc", dec_pc, m_dec);
      check("flush", {31'b0, flush}, {31'b0, m_redir});
      check("taken_cnt", {16'b0, taken_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
      check("pc_w2", pc2, m_pc);
      check("dec_pc_w2", dec_pc2, m_dec);
      check("flush_w2", {31'b0, flush2}, {31'b0, m_redir});
      check("taken_cnt_w2", {30'b0, taken_cnt2}, (m_cnt > 3) ? 32'd3 : m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_valid = 0; bcres = 2'b00; br_offset = 0; jmp_valid = 0; jmp_target = 0;
  endtask

  task automatic reset_and_advance(input int n);
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("reset_pc", pc, 32'h0);
    check("reset_dec_pc", dec_pc, 32'h0);
    check("reset_flush", {31'b0, flush}, 32'h0);
    check("reset_cnt", {16'b0, taken_cnt}, 32'h0);

    // sequential advance
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("seq_pc", pc, 32'(4 * k));
      check("seq_flush", {31'b0, flush}, 32'h0);
    end

    // taken forward branch from dec_pc 0x10
    tick();
    check("pre_br_dec", dec_pc, 32'h10);
    br_valid = 1; bcres = 2'b01; br_offset = 32'h3;
    tick();
    idle();
    check("br_pc", pc, 32'h20);
    check("br_flush", {31'b0, flush}, 32'h1);
    check("br_cnt", {16'b0, taken_cnt}, 32'h1);
    tick();
    check("br_after_pc", pc, 32'h24);
    check("br_after_flush", {31'b0, flush}, 32'h0);

    // backward branch taken and not taken from dec_pc 0x40
    reset_and_advance(17);
    check("bwd_dec", dec_pc, 32'h40);
    br_valid = 1; bcres = 2'b01; br_offset = 32'hFFFF_FFFE;
    tick();
    idle();
    check("bwd_pc", pc, 32'h3C);
    reset_and_advance(17);
    br_valid = 1; bcres = 2'b00; br_offset = 32'hFFFF_FFFE;
    tick();
    idle();
    check("nt_pc", pc, 32'h48);
    check("nt_flush", {31'b0, flush}, 32'h0);

    // jump priority over branch
    reset_and_advance(2);
    jmp_valid = 1; jmp_target = 32'h100; br_valid = 1; bcres = 2'b01; br_offset = 32'h3;
    tick();
    idle();
    check("jmp_pc", pc, 32'h100);
    check("jmp_cnt", {16'b0, taken_cnt}, 32'h1);

    // stall with pending branch, then stall inside REDIR
    reset_and_advance(5);
    br_valid = 1; bcres = 2'b01; br_offset = 32'h3; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h14);
      check("stall_flush", {31'b0, flush}, 32'h0);
    end
    stall = 0;
    tick();
    check("unstall_pc", pc, 32'h20);
    check("unstall_flush", {31'b0, flush}, 32'h1);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("redir_stall_flush", {31'b0, flush}, 32'h1);
      check("redir_stall_pc", pc, 32'h20);
    end
    idle();
    tick();
    check("redir_exit_pc", pc, 32'h24);
    check("redir_exit_flush", {31'b0, flush}, 32'h0);

    // reset during REDIR
    reset_and_advance(1);
    jmp_valid = 1; jmp_target = 32'h200;
    tick();
    check("pre_rst_flush", {31'b0, flush}, 32'h1);
    rst = 1;
    tick();
    rst = 0;
    idle();
    check("rst_redir_pc", pc, 32'h0);
    check("rst_redir_flush", {31'b0, flush}, 32'h0);
    check("rst_redir_cnt", {16'b0, taken_cnt}, 32'h0);

    // saturation of the narrow counter
    reset_and_advance(0);
    for (int i = 0; i < 5; i++) begin
      jmp_valid = 1; jmp_target = 32'h80;
      tick();
      idle();
      tick();
    end
    check("sat_cnt_w2", {30'b0, taken_cnt2}, 32'h3);
    check("sat_cnt_w16", {16'b0, taken_cnt}, 32'h5);

    // address wrap at the top of the space
    reset_and_advance(0);
    jmp_valid = 1; jmp_target = 32'hFFFF_FFF8;
    tick();
    idle();
    tick();
    check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", pc, 32'h0);

    // randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      stall      = ($urandom_range(0, 99) < 25);
      br_valid   = ($urandom_range(0, 99) < 40);
      bcres      = 2'($urandom_range(0, 3));
      br_offset  = $urandom_range(0, 1) ? (32'($urandom_range(0, 63)) - 32'd32) : $urandom;
      jmp_valid  = ($urandom_range(0, 99) < 15);
      jmp_target = {$urandom} & 32'hFFFF_FFFC;
      tick();
    end
    idle();
    rst = 0;
    tick();
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
